// File: rtl/mem_bist_ctrl.sv
// March C- BIST controller that owns a single-port mem during a test and forwards the host port otherwise.
// Define BIST_WALK_EN to append walking-one element M6 (w 1<<j, r 1<<j per bit, then w0) after M5.
module mem_bist_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_data,
  output logic [2:0]       fail_elem,
  input  logic             host_wen,
  input  logic             host_ren,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_wr_data,
  output logic             host_stall,
  output logic             mem_wen,
  output logic             mem_ren,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  input  logic [WIDTH-1:0] mem_rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_t;

`ifdef BIST_WALK_EN
  localparam logic [2:0] LAST_ELEM = 3'd6;
  localparam int BW = $clog2(WIDTH + 1);
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] walk_word;
  logic             walk_clear;
`else
  localparam logic [2:0] LAST_ELEM = 3'd5;
`endif

  state_t           state_q, state_d;
  logic [2:0]       elem_q, elem_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             pass_q, pass_d, fail_q, fail_d;
  logic [AW-1:0]    fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0] fail_data_q, fail_data_d;
  logic [2:0]       fail_elem_q, fail_elem_d;
  logic             desc, addr_last, adv;
  logic [WIDTH-1:0] exp_word, wr_word;

  assign desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign addr_last = desc ? (addr_q == '0) : (addr_q == AW'(DEPTH - 1));

`ifdef BIST_WALK_EN
  // bit_q == WIDTH marks the trailing w0 that leaves the word cleared
  assign walk_clear = (bit_q == BW'(WIDTH));
  assign walk_word  = walk_clear ? '0 : (WIDTH'(1) << bit_q);
`endif

  always_comb begin
    exp_word = '0;
    wr_word  = '0;
    case (elem_q)
      3'd1, 3'd3: wr_word  = '1;
      3'd2, 3'd4: exp_word = '1;
`ifdef BIST_WALK_EN
      3'd6: begin
        exp_word = walk_word;
        wr_word  = walk_word;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    adv         = 1'b0;
`ifdef BIST_WALK_EN
    bit_d       = bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WR;
          elem_d  = 3'd0;
          addr_d  = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
`ifdef BIST_WALK_EN
          bit_d   = '0;
`endif
        end
      end
      S_WR: begin
`ifdef BIST_WALK_EN
        if (elem_q == 3'd6 && !walk_clear) state_d = S_RD;
        else adv = 1'b1;
`else
        adv = 1'b1;
`endif
      end
      S_RD: state_d = S_CMP;
      S_CMP: begin
        if (mem_rd_data != exp_word) begin
          state_d     = S_DONE;
          fail_d      = 1'b1;
          fail_addr_d = addr_q;
          fail_data_d = mem_rd_data;
          fail_elem_d = elem_q;
        end else if (elem_q == 3'd5) begin
          adv = 1'b1;
`ifdef BIST_WALK_EN
        end else if (elem_q == 3'd6) begin
          bit_d   = bit_q + 1'b1;
          state_d = S_WR;
`endif
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End of the ops at one address: step the counter or roll into the next element
    if (adv) begin
      if (addr_last) begin
        if (elem_q == LAST_ELEM) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else begin
          elem_d  = elem_q + 3'd1;
          addr_d  = (elem_q == 3'd2 || elem_q == 3'd3) ? AW'(DEPTH - 1) : '0;
          state_d = (elem_q == 3'd5) ? S_WR : S_RD;
        end
      end else begin
        addr_d  = desc ? addr_q - 1'b1 : addr_q + 1'b1;
        state_d = (elem_q == 3'd0 || elem_q == 3'd6) ? S_WR : S_RD;
      end
`ifdef BIST_WALK_EN
      bit_d = '0;
`endif
    end
  end

  always_comb begin
    mem_wen     = 1'b0;
    mem_ren     = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      S_WR: begin
        mem_wen     = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = wr_word;
      end
      S_RD: begin
        mem_ren  = 1'b1;
        mem_addr = addr_q;
      end
      S_IDLE, S_DONE: begin
        if (!res) begin
          mem_wen     = host_wen;
          mem_ren     = host_ren & ~host_wen;
          mem_addr    = host_addr;
          mem_wr_data = host_wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
`ifdef BIST_WALK_EN
      bit_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
`ifdef BIST_WALK_EN
      bit_q       <= bit_d;
`endif
    end
  end

  assign busy       = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CMP);
  assign host_stall = busy;
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_elem  = fail_elem_q;

endmodule
